memory_stage: RTL
=================

Name: memory_stage

Overview:
- Y86-64 pipeline MEM stage; sits directly downstream of the execute stage and consumes its M-register outputs (M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM).
- Performs data-memory reads and writes against an internal byte-addressed, little-endian data memory.
- Produces m_stat and m_valM combinationally, for forwarding and for the pipeline controller.
- Owns the W pipeline register that feeds writeback.

Parameters:
- DMEM_BYTES, 1024: data memory size in bytes. Must be a multiple of 8 and at least 8.
- ADDR_W, 64: width of the effective address compared against DMEM_BYTES.

Ports:
- clk  in  1  stage clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- M_stat  in  2  status of the instruction in M: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- M_icode  in  4  instruction code.
- M_valE  in  64  ALU result.
- M_valA  in  64  store data / stack pointer source.
- M_dstE  in  4  register destination for valE (15 = none).
- M_dstM  in  4  register destination for valM (15 = none).
- W_stall  in  1  hold the W register.
- W_bubble  in  1  load nop into the W register.
- m_stat  out  2  combinational status after the memory access.
- m_valM  out  64  combinational read data.
- W_stat  out  2  registered status.
- W_icode  out  4  registered icode.
- W_valE  out  64  registered valE.
- W_valM  out  64  registered valM.
- W_dstE  out  4  registered dstE.
- W_dstM  out  4  registered dstM.

Behaviour:
- Address select:
  - icode 4 (rmmovq), 5 (mrmovq), 8 (call), 10 (pushq): addr = M_valE.
  - icode 9 (ret), 11 (popq): addr = M_valA.
  - All other icodes: no access.
- Read enable: icode 5, 9, 11. Write enable: icode 4, 8, 10. Write data is always M_valA.
- dmem_error: an access is requested and the address is out of range, i.e. addr > DMEM_BYTES-8 (unsigned full-width compare; no wrap-around).
- m_stat: 2 (ADR) when dmem_error; otherwise M_stat.
- m_valM:
  - Read with no error: bytes addr..addr+7, little-endian (byte at addr is bits 7:0).
  - Otherwise: 0.
  - Zero latency: purely combinational from M inputs and memory contents.
- Write commit: on posedge clk, 8 bytes little-endian, only when all of the following hold:
  - write enable is active;
  - dmem_error == 0;
  - M_stat == AOK;
  - W_stat is neither ADR, INS nor HLT (no writes after a faulting older instruction);
  - rst == 0.
- Read-during-write to the same address in one cycle returns the old data. The new data is visible the following cycle.
- W register update on posedge clk:
  - rst asserted (asynchronously): W_stat=0, W_icode=1 (nop), W_valE=0, W_valM=0, W_dstE=15, W_dstM=15.
  - W_stall=1: hold all W values. Stall has priority over bubble when both are asserted.
  - W_bubble=1 (no stall): load the reset values above.
  - Otherwise: W_stat=m_stat, W_icode=M_icode, W_valE=M_valE, W_valM=m_valM, W_dstE=M_dstE, W_dstM=M_dstM.
- Reset behaviour:
  - Reset does not clear memory contents; memory is zeroed at time 0 only.
  - Reset asserted mid-cycle suppresses that cycle's write.
  - Reset deasserting does not itself cause an access.
- Internal state is the W register plus the memory array; no other FSM.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: an access whose addr[2:0] != 0 also sets dmem_error, so m_stat=ADR, the write is suppressed and m_valM=0.
- Undefined: unaligned 8-byte accesses are legal and byte-assembled as normal.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT..IPOPQ, INOP=1;
  - stat codes: SAOK=0, SHLT=1, SADR=2, SINS=3;
  - RNONE=15.
- One sub-module, dmem:
  - byte array with combinational 8-byte little-endian read port and synchronous 8-byte write port;
  - write-enable input and range/alignment error output.
- memory_stage contains address/enable decode, status logic and the W register.

Test Plan:
- Store then load: rmmovq M_valE=0x40, M_valA=0x1122334455667788, then mrmovq M_valE=0x40 -> m_valM=0x1122334455667788, byte 0x40 = 0x88, W_valM matches one cycle later.
- Bounds check, DMEM_BYTES=1024:
  - mrmovq M_valE=1016 -> m_stat=AOK;
  - M_valE=1017 -> m_stat=2, m_valM=0, W_stat=2 next cycle;
  - pushq M_valE=0xFFFFFFFFFFFFFFF8 -> m_stat=2, memory unchanged.
- Write suppression: W_stat=2 held via W_stall, then rmmovq to 0x80 with 0xAA -> location 0x80 still 0. After rst and a new store -> value written.
- Stall/bubble: W_stall=1 holds W_valE=0x5 across 3 cycles despite new M inputs. W_stall=W_bubble=1 -> hold. W_bubble=1 only -> W_icode=1, W_dstE=W_dstM=15.
- Async reset: assert rst mid-cycle with a pending pushq -> W outputs go to nop/15 immediately, no memory write, memory retains earlier data.
- With DMEM_ALIGN_CHECK_EN: mrmovq M_valE=0x43 -> m_stat=2. Without it -> m_valM = bytes 0x43..0x4A.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants for the pipeline stages.
// This covers the instruction codes, the status codes, the "no register" code,
// and the layout of the W pipeline register together with its nop value.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } w_reg_t;

    // A bubble in writeback: nop that writes no register.
    function automatic w_reg_t w_nop();
        w_reg_t w;
        w.stat  = SAOK;
        w.icode = INOP;
        w.val_e = 64'd0;
        w.val_m = 64'd0;
        w.dst_e = RNONE;
        w.dst_m = RNONE;
        return w;
    endfunction

endpackage

// File: rtl/dmem.sv
// dmem: byte-addressed little-endian data memory for the MEM stage.
// It has an 8-byte combinational read port and an 8-byte synchronous write port.
// The error output flags a requested access that would run past the end of the array.
// Optional: with DMEM_ALIGN_CHECK_EN defined, an access whose address is not a
// multiple of 8 is also flagged as an error.
// The contents are never reset; they start at zero only at time 0.
module dmem
    import y86_pkg::*;
#(
    parameter int DMEM_BYTES = 1024,
    parameter int ADDR_W     = 64
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              access,
    input  logic              we,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              error
);

    localparam int IDX_W = $clog2(DMEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(DMEM_BYTES - 8);

    logic [7:0]       mem [DMEM_BYTES];
    logic [IDX_W-1:0] base;

    assign base = addr[IDX_W-1:0];

    // Compare against the full-width address so that huge addresses cannot wrap back into range.
`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        error = access && ((addr > LAST_BASE) || (addr[2:0] != 3'd0));
    end
`else
    always_comb begin
        error = access && (addr > LAST_BASE);
    end
`endif

    // Assemble 8 bytes little-endian starting at the base address; byte at base lands in bits 7:0.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < 8; k++) begin
            rdata[8*k +: 8] = mem[base + IDX_W'(k)];
        end
    end

    // Commit an 8-byte store at the clock edge. Reads in the same cycle still see the old bytes.
    always_ff @(posedge clk) begin
        if (we && !error) begin
            for (int k = 0; k < 8; k++) begin
                mem[base + IDX_W'(k)] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 pipeline MEM stage.
// It decodes the memory access from the M register and drives m_stat and m_valM
// combinationally for forwarding. It also owns the W pipeline register.
// Optional: DMEM_ALIGN_CHECK_EN (handled inside dmem) turns unaligned accesses into ADR faults.
module memory_stage
    import y86_pkg::*;
#(
    parameter int DMEM_BYTES = 1024,
    parameter int ADDR_W     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [1:0]  m_stat,
    output logic [63:0] m_valM,
    output logic [1:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic              write_commit;
    logic              dmem_error;
    logic [63:0]       rd_data;
    w_reg_t            w_q;
    w_reg_t            w_next;

    // Pick the address and the access direction from the instruction code.
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (M_icode)
            IRMMOVQ, ICALL, IPUSHQ: begin
                mem_addr  = ADDR_W'(M_valE);
                mem_write = 1'b1;
            end
            IMRMOVQ: begin
                mem_addr = ADDR_W'(M_valE);
                mem_read = 1'b1;
            end
            IRET, IPOPQ: begin
                mem_addr = ADDR_W'(M_valA);
                mem_read = 1'b1;
            end
            default: ;
        endcase
    end

    // Stores only retire from a healthy instruction, and only while the older instruction
    // in W has not faulted or halted. A reset during the cycle also cancels the store.
    always_comb begin
        write_commit = mem_write && (M_stat == SAOK) && (w_q.stat == SAOK) && !rst;
    end

    dmem #(
        .DMEM_BYTES (DMEM_BYTES),
        .ADDR_W     (ADDR_W)
    ) u_dmem (
        .clk    (clk),
        .addr   (mem_addr),
        .access (mem_read | mem_write),
        .we     (write_commit),
        .wdata  (M_valA),
        .rdata  (rd_data),
        .error  (dmem_error)
    );

    // Forwarded status and load data; faulting or non-load instructions produce zero data.
    always_comb begin
        m_stat = dmem_error ? SADR : M_stat;
        m_valM = (mem_read && !dmem_error) ? rd_data : 64'd0;
    end

    // Value the W register takes when the pipeline advances normally.
    always_comb begin
        w_next.stat  = m_stat;
        w_next.icode = M_icode;
        w_next.val_e = M_valE;
        w_next.val_m = m_valM;
        w_next.dst_e = M_dstE;
        w_next.dst_m = M_dstM;
    end

    // W pipeline register. Stall wins over bubble; both reset and bubble load a nop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= w_nop();
        end else if (W_stall) begin
            w_q <= w_q;
        end else if (W_bubble) begin
            w_q <= w_nop();
        end else begin
            w_q <= w_next;
        end
    end

    assign W_stat  = w_q.stat;
    assign W_icode = w_q.icode;
    assign W_valE  = w_q.val_e;
    assign W_valM  = w_q.val_m;
    assign W_dstE  = w_q.dst_e;
    assign W_dstM  = w_q.dst_m;

endmodule
